uart_mmio: RTL and testbench

Memory-mapped bridge between the CPU memory stage and the `uart_trans` byte FIFOs. It decodes CPU load and store requests to a small register window. Stores to DATA push bytes into the transmit FIFO. Loads from DATA pop the receive FIFO, and loads from STATUS report FIFO state. It drives the `send_flag`/`recv_flag` handshakes that `uart_trans` expects and returns one response per accepted request.

---
 rtl/uart_mmio.sv | 167 ++++++++++++++++
 tb/tb_uart_mmio.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio.sv
// CPU load/store bridge onto the uart_trans TX/RX byte FIFOs (DATA, STATUS, optional CTRL).
// Define UART_MMIO_IRQ_EN to add the CTRL register and the registered irq output.
module uart_mmio #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0001_0000,
    parameter int                    TX_TIMEOUT = 65535
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [7:0]            req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  send_flag,
    output logic [7:0]            send_data,
    output logic                  recv_flag,
    input  logic [7:0]            recv_data,
    input  logic                  sendable,
    input  logic                  receivable
`ifdef UART_MMIO_IRQ_EN
    ,
    output logic                  irq
`endif
);

    typedef enum logic [2:0] {IDLE, WAIT_TX, POP, CAPTURE, RESP} state_t;

    localparam logic [16:0] TO_LIMIT = 17'(TX_TIMEOUT);

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [7:0]  wdata_q;
    logic [1:0]  ctrl;

    logic        hit, is_data, is_stat, is_ctrl, accept;
    logic        do_resp, do_push, do_pop, ctrl_we, err_n;
    logic [31:0] rdata_n;
    logic [7:0]  push_byte;

    assign req_ready = (state == IDLE) && !RST;
    assign accept    = req_valid && (state == IDLE);
    assign hit       = req_addr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4];
    assign is_data   = hit && (req_addr[3:0] == 4'h0);
    assign is_stat   = hit && (req_addr[3:0] == 4'h4);
`ifdef UART_MMIO_IRQ_EN
    assign is_ctrl   = hit && (req_addr[3:0] == 4'h8);
`else
    assign is_ctrl   = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) wdata_q <= req_wdata;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        do_resp   = 1'b0;
        do_push   = 1'b0;
        do_pop    = 1'b0;
        ctrl_we   = 1'b0;
        err_n     = 1'b0;
        rdata_n   = '0;
        push_byte = wdata_q;
        case (state)
            IDLE: if (accept) begin
                if (is_data && req_we) begin
                    if (sendable) begin
                        do_resp   = 1'b1;
                        do_push   = 1'b1;
                        push_byte = req_wdata;
                    end else begin
                        state_n = WAIT_TX;
                        cnt_n   = '0;
                    end
                end else if (is_data) begin
                    if (receivable) begin
                        state_n = POP;
                        do_pop  = 1'b1;
                    end else begin
                        do_resp = 1'b1;
                        rdata_n = 32'h0000_0100;
                    end
                end else if (is_stat) begin
                    do_resp = 1'b1;
                    if (!req_we) rdata_n = {30'b0, sendable, receivable};
                end else if (is_ctrl) begin
                    do_resp = 1'b1;
                    ctrl_we = req_we;
                    if (!req_we) rdata_n = {30'b0, ctrl};
                end else begin
                    do_resp = 1'b1;
                    err_n   = 1'b1;
                end
            end
            WAIT_TX: begin
                if (sendable) begin
                    do_resp = 1'b1;
                    do_push = 1'b1;
                end else if (TX_TIMEOUT != 0 && ({1'b0, cnt} + 17'd1) == TO_LIMIT) begin
                    do_resp = 1'b1;
                    err_n   = 1'b1;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            POP:     state_n = CAPTURE;
            CAPTURE: begin
                do_resp = 1'b1;
                rdata_n = {24'b0, recv_data};
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (do_resp) state_n = RESP;
    end

    // Handshake and response outputs are registered so each pulse lasts exactly one cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            send_flag  <= 1'b0;
            send_data  <= '0;
            recv_flag  <= 1'b0;
        end else begin
            resp_valid <= do_resp;
            send_flag  <= do_push;
            recv_flag  <= do_pop;
            if (do_resp) begin
                resp_err   <= err_n;
                resp_rdata <= rdata_n;
            end
            if (do_push) send_data <= push_byte;
        end
    end

`ifdef UART_MMIO_IRQ_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ctrl <= '0;
            irq  <= 1'b0;
        end else begin
            if (ctrl_we) ctrl <= req_wdata[1:0];
            irq <= (ctrl[0] & receivable) | (ctrl[1] & sendable);
        end
    end
`else
    assign ctrl = 2'b00;
    logic unused_ok;
    assign unused_ok = ctrl_we;
`endif

endmodule

// File: tb/tb_uart_mmio.sv
// Bench for uart_mmio: directed cases plus random requests scored against a FIFO-level model.
module tb_uart_mmio;
    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam int          TO   = 8;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr;
    logic [7:0]  req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        send_flag, recv_flag;
    logic [7:0]  send_data;
    logic [7:0]  recv_data = 8'h00;
    logic        sendable, receivable;
`ifdef UART_MMIO_IRQ_EN
    logic        irq;
`endif

    int checks = 0, errors = 0;

    always #5 CLK = ~CLK;

    uart_mmio #(.ADDR_WIDTH(32), .BASE_ADDR(BASE), .TX_TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .send_flag(send_flag), .send_data(send_data),
        .recv_flag(recv_flag), .recv_data(recv_data),
        .sendable(sendable), .receivable(receivable)
`ifdef UART_MMIO_IRQ_EN
        , .irq(irq)
`endif
    );

    // RX FIFO model: initial block writes, pop side advances on recv_flag.
    logic [7:0] rx_mem [256];
    int rx_wr = 0, rx_rd = 0;
    assign receivable = (rx_wr != rx_rd);
    always @(posedge CLK) if (recv_flag) begin
        recv_data <= rx_mem[rx_rd[7:0]];
        rx_rd     <= rx_rd + 1;
    end

    // TX side observer and flag-rule watcher.
    int         n_push = 0, flag_err = 0;
    logic [7:0] last_push = 8'h00;
    logic       prev_flag = 1'b0;
    always @(posedge CLK) begin
        if (send_flag) begin
            n_push    <= n_push + 1;
            last_push <= send_data;
        end
        if ((send_flag && recv_flag) || (prev_flag && (send_flag || recv_flag)))
            flag_err <= flag_err + 1;
        prev_flag <= send_flag | recv_flag;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rx_push(input logic [7:0] b);
        rx_mem[rx_wr[7:0]] = b;
        rx_wr++;
    endtask

    // One request; raise>0 lifts sendable that many cycles after the accept edge.
    task automatic xact(input logic we, input logic [31:0] addr, input logic [7:0] wd,
                        input int raise, output logic [31:0] rd, output logic err, output int lat);
        @(negedge CLK);
        chk("ready_before_req", {31'b0, req_ready}, 1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        @(negedge CLK);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 40) begin
            if (lat == raise) sendable = 1'b1;
            @(negedge CLK);
            lat++;
        end
        chk("resp_seen", {31'b0, resp_valid}, 1);
        rd  = resp_rdata;
        err = resp_err;
        chk("ready_low_in_resp", {31'b0, req_ready}, 0);
        @(posedge CLK); #1;
    endtask

    logic [31:0] rd;
    logic        err;
    int          lat, p0, q0;

    initial begin
        RST = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; sendable = 1'b0;
        #12;
        chk("rst_resp_valid", {31'b0, resp_valid}, 0);
        chk("rst_resp_err", {31'b0, resp_err}, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_send_flag", {31'b0, send_flag}, 0);
        chk("rst_send_data", {24'b0, send_data}, 0);
        chk("rst_recv_flag", {31'b0, recv_flag}, 0);
        chk("rst_req_ready", {31'b0, req_ready}, 0);
`ifdef UART_MMIO_IRQ_EN
        chk("rst_irq", {31'b0, irq}, 0);
`endif
        @(negedge CLK); RST = 1'b0;

        // store DATA, FIFO has room
        sendable = 1'b1; p0 = n_push;
        xact(1'b1, BASE, 8'h41, 0, rd, err, lat);
        chk("st_err", {31'b0, err}, 0);
        chk("st_lat", lat, 1);
        chk("st_pushes", n_push - p0, 1);
        chk("st_byte", {24'b0, last_push}, 32'h41);

        // load DATA with a byte waiting
        rx_push(8'h5A); q0 = rx_rd;
        xact(1'b0, BASE, 8'h00, 0, rd, err, lat);
        chk("ld_lat", lat, 3);
        chk("ld_rdata", rd, 32'h5A);
        chk("ld_err", {31'b0, err}, 0);
        chk("ld_pops", rx_rd - q0, 1);

        // load DATA, RX empty
        q0 = rx_rd;
        xact(1'b0, BASE, 8'h00, 0, rd, err, lat);
        chk("ldE_lat", lat, 1);
        chk("ldE_rdata", rd, 32'h100);
        chk("ldE_pops", rx_rd - q0, 0);

        // store with TX full: timeout, then late sendable
        sendable = 1'b0; p0 = n_push;
        xact(1'b1, BASE, 8'h33, 0, rd, err, lat);
        chk("to_err", {31'b0, err}, 1);
        chk("to_lat_window", {31'b0, (lat >= TO && lat <= TO + 2)}, 1);
        chk("to_pushes", n_push - p0, 0);
        xact(1'b1, BASE, 8'h33, 3, rd, err, lat);
        chk("late_err", {31'b0, err}, 0);
        chk("late_lat", lat, 4);
        chk("late_pushes", n_push - p0, 1);
        chk("late_byte", {24'b0, last_push}, 32'h33);

        // bad offset and window miss
        p0 = n_push; q0 = rx_rd;
        xact(1'b0, BASE + 32'hC, 8'h00, 0, rd, err, lat);
        chk("off_err", {31'b0, err}, 1);
        chk("off_rdata", rd, 0);
        chk("off_lat", lat, 1);
        xact(1'b1, 32'h0002_0000, 8'h77, 0, rd, err, lat);
        chk("miss_err", {31'b0, err}, 1);
        chk("miss_rdata", rd, 0);
        chk("bad_no_flags", (n_push - p0) + (rx_rd - q0), 0);

        // STATUS: sendable=1, RX empty
        xact(1'b0, BASE + 32'h4, 8'h00, 0, rd, err, lat);
        chk("stat_rdata", rd, 32'h2);
        chk("stat_lat", lat, 1);

`ifdef UART_MMIO_IRQ_EN
        xact(1'b1, BASE + 32'h8, 8'h01, 0, rd, err, lat);
        chk("ctrl_wr_err", {31'b0, err}, 0);
        @(negedge CLK);
        chk("irq_idle", {31'b0, irq}, 0);
        rx_push(8'hC3);
        @(negedge CLK);
        chk("irq_rx", {31'b0, irq}, 1);
        xact(1'b0, BASE + 32'h8, 8'h00, 0, rd, err, lat);
        chk("ctrl_rd", rd, 32'h1);
        xact(1'b1, BASE + 32'h8, 8'h00, 0, rd, err, lat);
        @(negedge CLK);
        chk("irq_cleared", {31'b0, irq}, 0);
        xact(1'b0, BASE, 8'h00, 0, rd, err, lat);
        chk("irq_drain", rd, 32'hC3);
`endif

        // random requests against the FIFO-level model
        for (int i = 0; i < 40; i++) begin
            int          op;
            logic        we, exp_err, chk_rd;
            logic [31:0] addr, exp_rd;
            logic [7:0]  wd;
            int          exp_lat, exp_push, exp_pop;
            op = $urandom_range(0, 5);
            wd = 8'($urandom);
            if ($urandom_range(0, 1) == 1) rx_push(8'($urandom));
            sendable = 1'($urandom_range(0, 1));
            p0 = n_push; q0 = rx_rd;
            exp_err = 1'b0; exp_rd = 32'h0; chk_rd = 1'b1; exp_lat = 1; exp_push = 0; exp_pop = 0;
            case (op)
                0: begin
                    we = 1'b1; addr = BASE; chk_rd = 1'b0;
                    if (sendable) exp_push = 1; else begin exp_err = 1'b1; exp_lat = -1; end
                end
                1: begin
                    we = 1'b0; addr = BASE;
                    if (rx_wr != rx_rd) begin exp_rd = {24'b0, rx_mem[rx_rd[7:0]]}; exp_lat = 3; exp_pop = 1; end
                    else exp_rd = 32'h100;
                end
                2: begin we = 1'b0; addr = BASE + 32'h4; exp_rd = {30'b0, sendable, (rx_wr != rx_rd)}; end
                3: begin we = 1'b1; addr = BASE + 32'h4; chk_rd = 1'b0; end
                4: begin we = 1'($urandom); addr = BASE + 32'hC; exp_err = 1'b1; end
                default: begin
                    we = 1'($urandom); addr = BASE ^ 32'h0000_1000 ^ ($urandom & 32'hFFFF_F0F0);
                    exp_err = 1'b1;
                end
            endcase
            xact(we, addr, wd, 0, rd, err, lat);
            chk("rnd_err", {31'b0, err}, {31'b0, exp_err});
            if (chk_rd) chk("rnd_rdata", rd, exp_rd);
            if (exp_lat > 0) chk("rnd_lat", lat, exp_lat);
            else chk("rnd_to_lat_window", {31'b0, (lat >= TO && lat <= TO + 2)}, 1);
            chk("rnd_pushes", n_push - p0, exp_push);
            chk("rnd_pops", rx_rd - q0, exp_pop);
            if (exp_push == 1) chk("rnd_push_byte", {24'b0, last_push}, {24'b0, wd});
        end

        // reset while a pop is in flight: no response, byte stays in the FIFO
        while (rx_wr != rx_rd) xact(1'b0, BASE, 8'h00, 0, rd, err, lat);
        rx_push(8'h9E); q0 = rx_rd;
        @(negedge CLK);
        req_valid = 1'b1; req_we = 1'b0; req_addr = BASE;
        @(negedge CLK);
        req_valid = 1'b0;
        chk("mid_pop_issued", {31'b0, recv_flag}, 1);
        RST = 1'b1; #1;
        chk("mid_recv_clr", {31'b0, recv_flag}, 0);
        chk("mid_ready_low", {31'b0, req_ready}, 0);
        @(negedge CLK); RST = 1'b0;
        lat = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            if (resp_valid) lat++;
        end
        chk("mid_no_resp", lat, 0);
        chk("mid_no_pop", rx_rd - q0, 0);
        xact(1'b0, BASE, 8'h00, 0, rd, err, lat);
        chk("mid_after_ld", rd, 32'h9E);

        chk("flag_rules", flag_err, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
